io_flag_ctrl: RTL and testbench

IO_FLAG_CTRL -- requirements
Module: io_flag_ctrl

---
 rtl/io_flag_ctrl.sv | 135 +++++++++++++
 tb/tb_io_flag_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/io_flag_ctrl.sv
// I/O flag controller: parallel and serial ports, skip logic and the interrupt request.
// Optional macro IO_IMSK_EN adds a writable interrupt mask loaded by IMK.
module io_flag_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_exec,
    input  logic [11:0] ir_io,
    input  logic [7:0]  ac_in,
    input  logic        intr_ack,
    output logic [7:0]  inpr_out,
    output logic        skip,
    output logic        ien,
    output logic        intr_req,
    input  logic        fgi_bsy,
    input  logic [7:0]  inpr_in,
    output logic        fgi,
    input  logic        fgo_bsy,
    output logic        fgo,
    output logic [7:0]  outr,
    input  logic [7:0]  rx_byte,
    input  logic        rx_rdy,
    input  logic        tx_rdy,
    output logic [7:0]  tx_byte,
    output logic        tx_start,
    output logic        overrun
);

    logic       op_inp, op_out, op_ski, op_sko, op_ion, op_iof, op_sio, op_pio;
    logic       iosel_reg, sfgi_reg, sfgo_reg, rx_rdy_q, tx_rdy_q;
    logic [7:0] srx_q;
    logic [3:0] imsk;
    logic       rx_rise, tx_rise, in_flag, out_flag;

    // Only an exact one-hot code is an instruction; anything else falls through as a no-op.
    assign op_inp = io_exec && (ir_io == 12'h800);
    assign op_out = io_exec && (ir_io == 12'h400);
    assign op_ski = io_exec && (ir_io == 12'h200);
    assign op_sko = io_exec && (ir_io == 12'h100);
    assign op_ion = io_exec && (ir_io == 12'h080);
    assign op_iof = io_exec && (ir_io == 12'h040);
    assign op_sio = io_exec && (ir_io == 12'h020);
    assign op_pio = io_exec && (ir_io == 12'h010);

`ifdef IO_IMSK_EN
    logic       op_imk;
    logic [3:0] imsk_reg;

    assign op_imk = io_exec && (ir_io == 12'h008);

    always_ff @(posedge clk) begin
        if (rst)
            imsk_reg <= 4'b1111;
        else if (op_imk)
            imsk_reg <= ac_in[3:0];
    end

    assign imsk = imsk_reg;
`else
    assign imsk = 4'b1111;
`endif

    assign rx_rise  = rx_rdy & ~rx_rdy_q;
    assign tx_rise  = tx_rdy & ~tx_rdy_q;
    assign in_flag  = iosel_reg ? sfgi_reg : fgi;
    assign out_flag = iosel_reg ? sfgo_reg : fgo;
    assign inpr_out = iosel_reg ? srx_q : inpr_in;
    assign skip     = (op_ski & in_flag) | (op_sko & out_flag);

    always_ff @(posedge clk) begin
        if (rst) begin
            iosel_reg <= 1'b0;
            fgi       <= 1'b0;
            fgo       <= 1'b1;
            sfgi_reg  <= 1'b0;
            sfgo_reg  <= 1'b1;
            ien       <= 1'b0;
            outr      <= 8'h00;
            tx_byte   <= 8'h00;
            tx_start  <= 1'b0;
            srx_q     <= 8'h00;
            rx_rdy_q  <= 1'b0;
            tx_rdy_q  <= 1'b1;
            overrun   <= 1'b0;
            intr_req  <= 1'b0;
        end else begin
            rx_rdy_q <= rx_rdy;
            tx_rdy_q <= tx_rdy;
            tx_start <= 1'b0;

            if (op_sio)
                iosel_reg <= 1'b1;
            else if (op_pio)
                iosel_reg <= 1'b0;

            // Parallel input: an INP clear beats a same-cycle device delivery.
            if (op_inp && !iosel_reg)
                fgi <= 1'b0;
            else if (!fgi_bsy && !fgi)
                fgi <= 1'b1;

            if (op_out && !iosel_reg)
                outr <= ac_in;
            if (op_out && !iosel_reg && fgo)
                fgo <= 1'b0;
            else if (!fgo_bsy && !fgo)
                fgo <= 1'b1;

            // Serial input: a new byte always lands; a same-cycle INP loses to it.
            if (rx_rise) begin
                srx_q    <= rx_byte;
                sfgi_reg <= 1'b1;
                if (sfgi_reg)
                    overrun <= 1'b1;
            end else if (op_inp && iosel_reg) begin
                sfgi_reg <= 1'b0;
            end

            if (op_out && iosel_reg && sfgo_reg) begin
                tx_byte  <= ac_in;
                tx_start <= 1'b1;
                sfgo_reg <= 1'b0;
            end else if (tx_rise) begin
                sfgo_reg <= 1'b1;
            end

            if (intr_ack || op_iof)
                ien <= 1'b0;
            else if (op_ion)
                ien <= 1'b1;

            intr_req <= ien & |(imsk & {sfgo_reg, sfgi_reg, fgo, fgi});
        end
    end

endmodule

// File: tb/tb_io_flag_ctrl.sv
// Directed bench for io_flag_ctrl: stimulus queues expected values tagged with a cycle,
// a negedge monitor pops and compares them against the outputs.
module tb_io_flag_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        io_exec = 1'b0;
    logic [11:0] ir_io = 12'h000;
    logic [7:0]  ac_in = 8'h00;
    logic        intr_ack = 1'b0;
    logic [7:0]  inpr_out;
    logic        skip, ien, intr_req;
    logic        fgi_bsy = 1'b1;
    logic [7:0]  inpr_in = 8'h5A;
    logic        fgi;
    logic        fgo_bsy = 1'b1;
    logic        fgo;
    logic [7:0]  outr;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_rdy = 1'b0;
    logic        tx_rdy = 1'b1;
    logic [7:0]  tx_byte;
    logic        tx_start;
    logic        overrun;

    io_flag_ctrl dut (
        .clk(clk), .rst(rst), .io_exec(io_exec), .ir_io(ir_io), .ac_in(ac_in),
        .intr_ack(intr_ack), .inpr_out(inpr_out), .skip(skip), .ien(ien),
        .intr_req(intr_req), .fgi_bsy(fgi_bsy), .inpr_in(inpr_in), .fgi(fgi),
        .fgo_bsy(fgo_bsy), .fgo(fgo), .outr(outr), .rx_byte(rx_byte),
        .rx_rdy(rx_rdy), .tx_rdy(tx_rdy), .tx_byte(tx_byte), .tx_start(tx_start),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    localparam logic [11:0] INP = 12'h800, OUT = 12'h400, SKI = 12'h200, SKO = 12'h100;
    localparam logic [11:0] ION = 12'h080, IOF = 12'h040, SIO = 12'h020, PIO = 12'h010;
    localparam logic [11:0] IMK = 12'h008;
    localparam int S_FGI = 0, S_FGO = 1, S_IEN = 2, S_IRQ = 3, S_SKIP = 4;
    localparam int S_INPR = 5, S_OUTR = 6, S_TXB = 7, S_TXS = 8, S_OVR = 9;

    typedef struct {
        int         cyc;
        int         id;
        logic [7:0] val;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] dut_val(int id);
        case (id)
            S_FGI:   return {7'd0, fgi};
            S_FGO:   return {7'd0, fgo};
            S_IEN:   return {7'd0, ien};
            S_IRQ:   return {7'd0, intr_req};
            S_SKIP:  return {7'd0, skip};
            S_INPR:  return inpr_out;
            S_OUTR:  return outr;
            S_TXB:   return tx_byte;
            S_TXS:   return {7'd0, tx_start};
            default: return overrun;
        endcase
    endfunction

    function automatic string sig_name(int id);
        case (id)
            S_FGI:   return "fgi";
            S_FGO:   return "fgo";
            S_IEN:   return "ien";
            S_IRQ:   return "intr_req";
            S_SKIP:  return "skip";
            S_INPR:  return "inpr_out";
            S_OUTR:  return "outr";
            S_TXB:   return "tx_byte";
            S_TXS:   return "tx_start";
            default: return "overrun";
        endcase
    endfunction

    // Monitor: compare every entry due at this cycle; a stale entry is a miss.
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc <= cyc) begin
                logic [7:0] got;
                got = dut_val(q[i].id);
                checks = checks + 1;
                if (q[i].cyc < cyc || got !== q[i].val) begin
                    errors = errors + 1;
                    $display("FAIL %s cyc=%0d got=%h want=%h", sig_name(q[i].id), cyc, got, q[i].val);
                end else begin
                    $display("ok   %s cyc=%0d value=%h", sig_name(q[i].id), cyc, got);
                end
                q.delete(i);
            end
        end
    end

    task automatic want(input int dly, input int id, input logic [7:0] v);
        exp_t e;
        e.cyc = cyc + dly;
        e.id  = id;
        e.val = v;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        io_exec  = 1'b0;
        ir_io    = 12'h000;
        intr_ack = 1'b0;
    endtask

    task automatic io(input logic [11:0] code);
        io_exec = 1'b1;
        ir_io   = code;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        step(); step();
        want(0, S_FGI, 8'h00); want(0, S_FGO, 8'h01); want(0, S_IEN, 8'h00);
        want(0, S_IRQ, 8'h00); want(0, S_OUTR, 8'h00); want(0, S_TXB, 8'h00);
        want(0, S_TXS, 8'h00); want(0, S_OVR, 8'h00); want(0, S_SKIP, 8'h00);
        want(0, S_INPR, 8'h5A);
        step();
        rst = 1'b0;

        // Parallel input
        fgi_bsy = 1'b0; want(0, S_FGI, 8'h00); want(1, S_FGI, 8'h01); step(); fgi_bsy = 1'b1;
        io(SKI); want(0, S_SKIP, 8'h01); step();
        io(SKO); want(0, S_SKIP, 8'h01); step();
        io(INP); want(0, S_INPR, 8'h5A); want(1, S_FGI, 8'h00); step();
        io(SKI); want(0, S_SKIP, 8'h00); step();
        fgi_bsy = 1'b0; io(INP); want(1, S_FGI, 8'h00); step(); fgi_bsy = 1'b1;

        // Parallel output
        ac_in = 8'hC3; io(OUT); want(1, S_OUTR, 8'hC3); want(1, S_FGO, 8'h00); step();
        io(SKO); want(0, S_SKIP, 8'h00); step();
        fgo_bsy = 1'b0; want(1, S_FGO, 8'h01); step(); fgo_bsy = 1'b1;
        ac_in = 8'h11; io(OUT); want(1, S_OUTR, 8'h11); want(1, S_FGO, 8'h00); step();
        fgo_bsy = 1'b0; ac_in = 8'h77; io(OUT);
        want(1, S_OUTR, 8'h77); want(1, S_FGO, 8'h01); step(); fgo_bsy = 1'b1;

        // Serial input with overrun and INP/rise collision
        io(SIO); step();
        want(0, S_INPR, 8'h00); rx_byte = 8'h41; rx_rdy = 1'b1; step();
        rx_rdy = 1'b0; io(SKI);
        want(0, S_SKIP, 8'h01); want(0, S_INPR, 8'h41); want(0, S_OVR, 8'h00); step();
        rx_byte = 8'h42; rx_rdy = 1'b1; want(1, S_OVR, 8'h01); step();
        rx_rdy = 1'b0; io(INP); want(0, S_INPR, 8'h42); step();
        io(SKI); want(0, S_SKIP, 8'h00); step();
        rx_byte = 8'h43; rx_rdy = 1'b1; io(INP); want(0, S_INPR, 8'h42); step();
        rx_rdy = 1'b0; io(SKI);
        want(0, S_SKIP, 8'h01); want(0, S_INPR, 8'h43); want(0, S_OVR, 8'h01); step();
        io(INP); step();

        // Serial output
        io(SKO); want(0, S_SKIP, 8'h01); step();
        ac_in = 8'h0D; io(OUT);
        want(1, S_TXS, 8'h01); want(1, S_TXB, 8'h0D); want(1, S_OUTR, 8'h77); step();
        ac_in = 8'hEE; io(OUT); want(1, S_TXS, 8'h00); want(1, S_TXB, 8'h0D); step();
        io(SKO); want(0, S_SKIP, 8'h00); step();
        tx_rdy = 1'b0; step(); tx_rdy = 1'b1; step();
        io(SKO); want(0, S_SKIP, 8'h01); step();

        // Interrupts: clear every flag except fgi first
        ac_in = 8'h22; io(OUT); want(1, S_TXB, 8'h22); step();
        io(PIO); step();
        ac_in = 8'h33; io(OUT); want(1, S_FGO, 8'h00); step();
        io(ION); want(1, S_IEN, 8'h01); want(2, S_IRQ, 8'h00); step(); step();
        fgi_bsy = 1'b0; want(1, S_FGI, 8'h01); want(2, S_IRQ, 8'h01); step(); fgi_bsy = 1'b1; step();
        ac_in = 8'h00; io(IMK);
`ifdef IO_IMSK_EN
        want(2, S_IRQ, 8'h00);
`else
        want(2, S_IRQ, 8'h01);
`endif
        step(); step();
        intr_ack = 1'b1; want(1, S_IEN, 8'h00); want(2, S_IRQ, 8'h00); step(); step();
        intr_ack = 1'b1; io(ION); want(1, S_IEN, 8'h00); step();
        io(ION); want(1, S_IEN, 8'h01); step();
        io(IOF); want(1, S_IEN, 8'h00); step();

        // Reset in the cycle after a serial OUT, colliding with device events
        io(SIO); step();
        tx_rdy = 1'b0; step(); tx_rdy = 1'b1; step();
        ac_in = 8'h55; io(OUT); want(1, S_TXS, 8'h01); step();
        rst = 1'b1; fgi_bsy = 1'b0; fgo_bsy = 1'b0; rx_rdy = 1'b1; rx_byte = 8'h99;
        want(1, S_TXS, 8'h00); want(1, S_TXB, 8'h00); want(1, S_FGI, 8'h00);
        want(1, S_FGO, 8'h01); want(1, S_IEN, 8'h00); want(1, S_OVR, 8'h00);
        want(1, S_OUTR, 8'h00); want(1, S_IRQ, 8'h00); want(1, S_INPR, 8'h5A);
        step();
        rst = 1'b0; fgi_bsy = 1'b1; fgo_bsy = 1'b1; rx_rdy = 1'b0;
        io(SIO); step();
        io(SKO); want(0, S_SKIP, 8'h01); want(0, S_INPR, 8'h00); step();
        io(SKI); want(0, S_SKIP, 8'h00); step();

        step(); step(); step();
        if (q.size() != 0) begin
            $display("FAIL pending got=%0d want=0 unchecked entries", q.size());
            errors = errors + q.size();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
